// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared widths, address windows, FSM and slave-select encodings.
package mem_bus_arbiter_pkg;
    localparam int DEF_ADDR_W   = 32;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_RAM_BASE = 0;
    localparam int DEF_RAM_SIZE = 1024;
    localparam int DEF_IO_BASE  = 1024;
    localparam int DEF_IO_SIZE  = 1024;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;
    localparam logic [1:0] SEL_RAM   = 2'd0;
    localparam logic [1:0] SEL_IO    = 2'd1;
    localparam logic [1:0] SEL_ERR   = 2'd2;
endpackage

// File: rtl/mem_addr_decode.sv
// mem_addr_decode: maps a word address onto the RAM or IO window, flagging misalignment and holes.
module mem_addr_decode
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int RAM_BASE = DEF_RAM_BASE,
    parameter int RAM_SIZE = DEF_RAM_SIZE,
    parameter int IO_BASE  = DEF_IO_BASE,
    parameter int IO_SIZE  = DEF_IO_SIZE
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [1:0]        sel,
    output logic              err
);
    logic in_ram, in_io;
    // unsigned offset compare avoids a constant-true lower bound when a base is 0
    assign in_ram = (addr - ADDR_W'(RAM_BASE)) < ADDR_W'(RAM_SIZE);
    assign in_io  = (addr - ADDR_W'(IO_BASE)) < ADDR_W'(IO_SIZE);
    assign err    = |addr[1:0] || !(in_ram || in_io);
    assign sel    = err ? SEL_ERR : in_ram ? SEL_RAM : SEL_IO;
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin two-master arbiter sequencing one RAM/IO access at a time
// through IDLE -> ACCESS -> RESP.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int RAM_BASE = DEF_RAM_BASE,
    parameter int RAM_SIZE = DEF_RAM_SIZE,
    parameter int IO_BASE  = DEF_IO_BASE,
    parameter int IO_SIZE  = DEF_IO_SIZE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        m_req,
    input  logic [1:0]        m_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [1:0]        m_ack,
    output logic [1:0]        m_err,
    output logic [DATA_W-1:0] m_rdata,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              io_ce,
    output logic              io_we,
    output logic [ADDR_W-1:0] io_addr,
    output logic [DATA_W-1:0] io_wdata,
    input  logic [DATA_W-1:0] io_rdata
);
    logic [1:0]        state, sel;
    logic              rr_last, win, nxt_win, lat_we, err, acc;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    mem_addr_decode #(
        .ADDR_W(ADDR_W), .RAM_BASE(RAM_BASE), .RAM_SIZE(RAM_SIZE),
        .IO_BASE(IO_BASE), .IO_SIZE(IO_SIZE)
    ) u_dec (
        .addr(lat_addr),
        .sel (sel),
        .err (err)
    );

    assign nxt_win = (m_req == 2'b11) ? ~rr_last : m_req[1];
    // slave strobes are gated by rst so a reset landing in ACCESS can never commit a write
    assign acc       = rst && state == ST_ACCESS;
    assign ram_ce    = acc && sel == SEL_RAM;
    assign ram_we    = ram_ce && lat_we;
    assign ram_addr  = ram_ce ? lat_addr : '0;
    assign ram_wdata = ram_we ? lat_wdata : '0;
    assign io_ce     = acc && sel == SEL_IO;
    assign io_we     = io_ce && lat_we;
    assign io_addr   = io_ce ? lat_addr : '0;
    assign io_wdata  = io_we ? lat_wdata : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            rr_last   <= 1'b1;
            win       <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            m_ack     <= 2'b00;
            m_err     <= 2'b00;
            m_rdata   <= '0;
        end else begin
            m_ack   <= 2'b00;
            m_err   <= 2'b00;
            m_rdata <= '0;
            if (state == ST_IDLE && |m_req) begin
                state     <= ST_ACCESS;
                win       <= nxt_win;
                rr_last   <= nxt_win;
                lat_we    <= m_we[nxt_win];
                lat_addr  <= nxt_win ? m1_addr : m0_addr;
                lat_wdata <= nxt_win ? m1_wdata : m0_wdata;
            end else if (state == ST_ACCESS) begin
                state   <= ST_RESP;
                m_ack   <= win ? 2'b10 : 2'b01;
                m_err   <= !err ? 2'b00 : win ? 2'b10 : 2'b01;
                m_rdata <= (err || lat_we) ? '0 : sel == SEL_RAM ? ram_rdata : io_rdata;
            end else begin
                state <= ST_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: vector table plus corner sequences against behavioural RAM/IO slaves,
// with a scoreboard of expected acks.
module tb_mem_bus_arbiter;
    logic        clk = 1'b0, rst = 1'b0, fill = 1'b1;
    logic [1:0]  m_req = 2'b00, m_we = 2'b00, m_ack, m_err;
    logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0, m_rdata;
    logic        ram_ce, ram_we, io_ce, io_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata, io_addr, io_wdata, io_rdata;

    always #5 clk = ~clk;

    mem_bus_arbiter dut (
        .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .io_ce(io_ce), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata)
    );

    logic [31:0] ram_m[256], io_m[256], ref_ram[256], ref_io[256];
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 256; i++) begin
                ram_m[i] <= 32'hA000_0000 | i;
                io_m[i]  <= 32'hB000_0000 | i;
            end
        end else begin
            if (ram_ce && ram_we) ram_m[ram_addr[9:2]] <= ram_wdata;
            if (io_ce && io_we) io_m[io_addr[9:2]] <= io_wdata;
        end
    end
    assign ram_rdata = ram_m[ram_addr[9:2]];
    assign io_rdata  = io_m[io_addr[9:2]];

    int checks = 0, failures = 0;
    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endfunction

    typedef struct {
        logic [1:0]  ack;
        logic        err;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb[$];

    int          ram_cnt = 0, io_cnt = 0, cyc = 0, last_ack_cyc = 0, ack_cnt = 0, gap_base = 0;
    logic        gap_chk = 1'b0;
    logic [31:0] last_slv_addr = '0;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (ram_ce) begin ram_cnt++; last_slv_addr = ram_addr; end
        if (io_ce) begin io_cnt++; last_slv_addr = io_addr; end
        if (ram_ce && io_ce) chk("dual_ce", 32'(ram_ce & io_ce), 32'd0);
        if (m_ack != 2'b00) begin
            if (sb.size() == 0) chk("unexpected_ack", 32'(m_ack), 32'd0);
            else begin
                e = sb.pop_front();
                chk("ack", 32'(m_ack), 32'(e.ack));
                chk("err", 32'(m_err), e.err ? 32'(e.ack) : 32'd0);
                chk("rdata", m_rdata, e.rdata);
            end
            if (gap_chk && ack_cnt > gap_base) chk("ack_gap", 32'(cyc - last_ack_cyc), 32'd3);
            last_ack_cyc = cyc;
            ack_cnt++;
        end else if (m_err != 2'b00) chk("err_without_ack", 32'(m_err), 32'd0);
    end

    function automatic exp_t expect_of(bit m, bit we, logic [31:0] addr, logic [31:0] wdata, bit err, int sel);
        exp_t e;
        e.ack   = m ? 2'b10 : 2'b01;
        e.err   = err;
        e.rdata = (err || we) ? 32'd0 : (sel == 0) ? ref_ram[addr[9:2]] : ref_io[addr[9:2]];
        if (we && !err) begin
            if (sel == 0) ref_ram[addr[9:2]] = wdata;
            else ref_io[addr[9:2]] = wdata;
        end
        return e;
    endfunction

    task automatic do_txn(input bit m, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input bit err, input int sel, input string tag);
        int rc0, ic0, n;
        rc0 = ram_cnt;
        ic0 = io_cnt;
        n = 0;
        sb.push_back(expect_of(m, we, addr, wdata, err, sel));
        @(negedge clk);
        m_req[m] = 1'b1;
        m_we[m]  = we;
        if (m) begin m1_addr = addr; m1_wdata = wdata; end
        else begin m0_addr = addr; m0_wdata = wdata; end
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!m_ack[m] && n < 20);
        chk({tag, "_latency"}, 32'(n), 32'd2);
        m_req[m] = 1'b0;
        m0_addr  = $urandom;
        m1_addr  = $urandom;
        @(posedge clk);
        chk({tag, "_ram_ce_cycles"}, 32'(ram_cnt - rc0), (sel == 0 && !err) ? 32'd1 : 32'd0);
        chk({tag, "_io_ce_cycles"}, 32'(io_cnt - ic0), (sel == 1 && !err) ? 32'd1 : 32'd0);
        if (!err) chk({tag, "_slave_addr"}, last_slv_addr, addr);
    endtask

    typedef struct {
        bit          m;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          err;
        int          sel;
    } vec_t;
    vec_t tv[13];

    initial begin
        int n;
        tv[0]  = '{1'b0, 1'b1, 32'h0000_0404, 32'hDEADBEEF, 1'b0, 1};
        tv[1]  = '{1'b0, 1'b0, 32'h0000_0404, 32'h0,        1'b0, 1};
        tv[2]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h12345678, 1'b0, 0};
        tv[3]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,        1'b0, 0};
        tv[4]  = '{1'b0, 1'b0, 32'h0000_0802, 32'h0,        1'b1, 2};
        tv[5]  = '{1'b1, 1'b1, 32'h0000_0800, 32'h0BADF00D, 1'b1, 2};
        tv[6]  = '{1'b0, 1'b0, 32'h0000_03FF, 32'h0,        1'b1, 2};
        tv[7]  = '{1'b1, 1'b1, 32'h0000_03FC, 32'hCAFE0001, 1'b0, 0};
        tv[8]  = '{1'b0, 1'b0, 32'h0000_03FC, 32'h0,        1'b0, 0};
        tv[9]  = '{1'b1, 1'b0, 32'h0000_0400, 32'h0,        1'b0, 1};
        tv[10] = '{1'b0, 1'b1, 32'h0000_07FC, 32'hCAFE0002, 1'b0, 1};
        tv[11] = '{1'b1, 1'b0, 32'h0000_07FC, 32'h0,        1'b0, 1};
        tv[12] = '{1'b0, 1'b0, 32'hFFFF_FC00, 32'h0,        1'b1, 2};
        for (int i = 0; i < 256; i++) begin
            ref_ram[i] = 32'hA000_0000 | i;
            ref_io[i]  = 32'hB000_0000 | i;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_strobes", {26'd0, ram_ce, ram_we, io_ce, io_we, m_ack}, 32'd0);
        chk("reset_err_rdata", m_rdata | 32'(m_err), 32'd0);
        chk("reset_slave_bus", ram_addr | ram_wdata | io_addr | io_wdata, 32'd0);
        @(negedge clk);
        fill = 1'b0;
        rst  = 1'b1;

        for (int i = 0; i < 13; i++)
            do_txn(tv[i].m, tv[i].we, tv[i].addr, tv[i].wdata, tv[i].err, tv[i].sel, $sformatf("vec%0d", i));

        // M1 drops req right after its grant; the write still completes and acks
        sb.push_back(expect_of(1'b1, 1'b1, 32'h20, 32'h55AA55AA, 1'b0, 0));
        @(negedge clk);
        m_req[1] = 1'b1; m_we[1] = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h55AA55AA;
        @(posedge clk);
        #1;
        m_req[1] = 1'b0;
        n = 0;
        do begin @(posedge clk); #2; n++; end while (!m_ack[1] && n < 10);
        chk("drop_req_ack_wait", 32'(n), 32'd1);
        @(posedge clk);
        do_txn(1'b0, 1'b0, 32'h20, 32'h0, 1'b0, 0, "drop_req_readback");

        // reset lands while a write to 0x404 is in ACCESS: no ack, no write
        @(negedge clk);
        m_req[0] = 1'b1; m_we[0] = 1'b1; m0_addr = 32'h404; m0_wdata = 32'hBADBAD00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_access_io_ce", {30'd0, io_ce, io_we}, 32'd0);
        @(posedge clk);
        #1;
        m_req = 2'b00;
        chk("rst_access_ack", {28'd0, m_ack, m_err}, 32'd0);
        chk("rst_access_outs", m_rdata | io_addr | io_wdata | ram_addr | 32'({ram_ce, io_ce}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        do_txn(1'b0, 1'b0, 32'h404, 32'h0, 1'b0, 1, "rst_readback");

        // both masters request continuously after a fresh reset: strict M0/M1 alternation
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++)
            sb.push_back(expect_of(i[0], 1'b0, i[0] ? 32'h404 : 32'h10, 32'h0, 1'b0, i[0] ? 1 : 0));
        m0_addr = 32'h10; m1_addr = 32'h404; m_we = 2'b00;
        gap_base = ack_cnt;
        gap_chk = 1'b1;
        m_req = 2'b11;
        n = 0;
        while (ack_cnt < gap_base + 6 && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        m_req = 2'b00;
        gap_chk = 1'b0;
        chk("alternate_acks", 32'(ack_cnt - gap_base), 32'd6);
        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master, two-slave arbiter and sequencer for the data address space: RAM at [0:1023], IO register file at [1024:2047].
- Masters: M0 is the CPU load/store stage; M1 is the debug/DMA port.
- Grants one access at a time, round-robin. Decodes the address to RAM or IO and drives exactly one slave ce/we for one cycle.
- Returns a one-cycle ack with read data or an error flag. The IO slave reads combinationally and writes on posedge; RAM follows the same contract.

Parameters:
- ADDR_W, 32, address width on master and slave ports
- DATA_W, 32, data width
- RAM_BASE, 0, first RAM byte address
- RAM_SIZE, 1024, RAM window size in bytes
- IO_BASE, 1024, first IO byte address
- IO_SIZE, 1024, IO window size in bytes

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  reset, synchronous, active-low (0 = reset)
- m_req  in  2  per-master request, bit i = master i
- m_we  in  2  per-master write enable, 1 = write
- m0_addr, m1_addr  in  ADDR_W  master byte addresses
- m0_wdata, m1_wdata  in  DATA_W  master write data
- m_ack  out  2  one-cycle completion pulse per master
- m_err  out  2  valid with m_ack; 1 = decode or alignment error
- m_rdata  out  DATA_W  read data, valid with the m_ack pulse
- ram_ce, ram_we  out  1  RAM select and write
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM combinational read data
- io_ce, io_we  out  1  IO select and write
- io_addr  out  ADDR_W  IO address
- io_wdata  out  DATA_W  IO write data
- io_rdata  in  DATA_W  IO combinational read data

Behaviour:
- Reset (rst=0 at posedge):
  - State goes to IDLE; rr_last is set to 1, so M0 wins the first tie.
  - All ce/we, m_ack and m_err go to 0.
  - addr, wdata and m_rdata go to 0. Outputs are never high-Z.
- FSM states IDLE -> ACCESS -> RESP -> IDLE. Each state lasts exactly one cycle.
- IDLE: if any m_req bit is set, pick the winner at the posedge.
  - A single requester wins.
  - If both request, the master that is not rr_last wins.
  - Latch the winner's id, we, addr and wdata into internal registers, update rr_last, and go to ACCESS.
  - After the grant edge the master may change addr/wdata. It must hold req until ack.
- ACCESS, decode on the latched address:
  - addr[1:0] != 0 -> error.
  - RAM_BASE <= addr < RAM_BASE+RAM_SIZE -> RAM.
  - IO_BASE <= addr < IO_BASE+IO_SIZE -> IO.
  - Anything else -> error.
  - The selected slave gets ce=1, we=latched we, addr, wdata for this cycle only. The other slave has ce=0. On error, both ce=0.
  - Writes commit at the posedge ending ACCESS. For reads, the selected slave's rdata is captured at that edge.
- RESP:
  - m_ack[winner]=1 for one cycle.
  - m_err[winner] is the decode result.
  - m_rdata = captured data for a read, 0 for a write or an error.
  - The other master's ack and err bits stay 0.
- Latency: grant edge to ack-high is 2 cycles. Back-to-back accesses run every 3 cycles.
- A master that keeps req=1 after its ack re-arbitrates in the next IDLE. With both requesting continuously, grants strictly alternate M0, M1, M0...
- Dropping req mid-transaction does not abort it: the access completes and ack still pulses.
- Reset mid-transaction returns to IDLE with no ack. If reset is sampled at the edge ending ACCESS, the outputs already registered as 0, so no write occurs.
- Boundary addresses:
  - 1023 with a word access is misaligned (error).
  - 1020 goes to RAM.
  - 1024 goes to IO.
  - 2044 goes to IO.
  - 2048 is an error.
- Slave addresses are passed unmasked. Address remapping is the slave's job.

Decomposition:
- Shared package constants: ADDR_W/DATA_W defaults, RAM/IO window bases and sizes, and state encodings (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2).
- Slave select encoding: SEL_RAM, SEL_IO, SEL_ERR.
- One natural combinational sub-module, mem_addr_decode: address in, select + err out. The arbiter FSM and round-robin pointer stay in the top.

Test Plan:
- Single M0 write 0x0000_0404 data 0xDEADBEEF, then read same -> io_ce=1 for exactly one cycle; read ack 2 cycles after grant with m_rdata=0xDEADBEEF; ram_ce stays 0.
- M1 read addr 0x10, RAM model returns 0x12345678 -> m_ack=2'b10, m_err=0, m_rdata=0x12345678; io_ce stays 0.
- Both requesting continuously for 6 transactions after reset -> grant order M0, M1, M0, M1, M0, M1; acks every 3 cycles.
- Addresses 0x802 (misaligned) and 0x800 (out of range) -> m_err=1, m_rdata=0, no ce asserted.
- Boundaries 1020, 1024, 2044 -> routed RAM, IO, IO respectively.
- Reset asserted (rst=0) during ACCESS of a write to 0x404 -> no ack; all outputs 0 next cycle; a read of 0x404 afterwards returns the old value.
